// File: rtl/avalon_st_arbiter_if.sv
// Avalon-ST arbiter bus: N_CH source ports merged onto one sink port.
// Signal names keep the arbiter's point of view (_i into the arbiter, _o out of it).
//   src_data_i    N_CH*WIDTH  source data, source k at [k*WIDTH +: WIDTH]
//   src_valid_i   N_CH        per-source valid
//   src_sop_i     N_CH        per-source start-of-packet
//   src_eop_i     N_CH        per-source end-of-packet
//   src_ready_o   N_CH        per-source ready (at most one high)
//   snk_data_o    WIDTH       registered sink data
//   snk_valid_o   1           registered sink valid
//   snk_sop_o     1           registered sink start-of-packet
//   snk_eop_o     1           registered sink end-of-packet
//   snk_channel_o CH_W        source index of the beat on snk_data_o
//   snk_ready_i   1           sink ready, ready latency 0
//   busy_o        1           arbiter holds a packet lock
// Modports: slave = the arbiter, master = the sources/sink environment.
interface avalon_st_arbiter_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned CH_W = $clog2(N_CH);

   logic [N_CH*WIDTH-1:0] src_data_i;
   logic [N_CH-1:0]       src_valid_i;
   logic [N_CH-1:0]       src_sop_i;
   logic [N_CH-1:0]       src_eop_i;
   logic [N_CH-1:0]       src_ready_o;
   logic [WIDTH-1:0]      snk_data_o;
   logic                  snk_valid_o;
   logic                  snk_sop_o;
   logic                  snk_eop_o;
   logic [CH_W-1:0]       snk_channel_o;
   logic                  snk_ready_i;
   logic                  busy_o;

   modport slave (
      input  src_data_i, src_valid_i, src_sop_i, src_eop_i, snk_ready_i,
      output src_ready_o, snk_data_o, snk_valid_o, snk_sop_o, snk_eop_o, snk_channel_o, busy_o
   );

   modport master (
      output src_data_i, src_valid_i, src_sop_i, src_eop_i, snk_ready_i,
      input  src_ready_o, snk_data_o, snk_valid_o, snk_sop_o, snk_eop_o, snk_channel_o, busy_o
   );
endinterface

// File: rtl/avalon_st_arbiter.sv
// Round-robin, packet-locked Avalon-ST arbiter. One source at a time is granted
// from its first accepted beat through its eop beat; accepted beats go through a
// single output register that also records the source index.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous, active-low reset
//   bus    avalon_st_arbiter_if.slave (sources in, sink out, busy)
module avalon_st_arbiter #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned WIDTH = 32
) (
   input logic                 clk_i,
   input logic                 rst_i,
   avalon_st_arbiter_if.slave  bus
);
   localparam int unsigned CH_W = $clog2(N_CH);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e           state_q;
   logic [CH_W-1:0]  grant_q;
   logic [CH_W-1:0]  last_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             sop_q;
   logic             eop_q;
   logic [CH_W-1:0]  channel_q;

   logic [CH_W-1:0]  next_win;
   logic [CH_W-1:0]  idx;
   logic             found;
   logic             out_free;
   logic             accept;
   logic [WIDTH-1:0] gnt_data;
   logic [N_CH-1:0]  ready;

   // First valid source scanning upward from last_q + 1, wrapping at N_CH.
   always_comb begin
      next_win = '0;
      idx      = '0;
      found    = 1'b0;
      for (int unsigned i = 1; i <= N_CH; i++) begin
         idx = CH_W'((32'(last_q) + i) % N_CH);
         if (!found && bus.src_valid_i[idx]) begin
            found    = 1'b1;
            next_win = idx;
         end
      end
   end

   // Output register can take a beat when empty or draining this cycle.
   assign out_free = !valid_q || bus.snk_ready_i;
   assign gnt_data = bus.src_data_i[32'(grant_q)*WIDTH +: WIDTH];
   assign accept   = (state_q == StLocked) && bus.src_valid_i[grant_q] && out_free;

   always_comb begin
      ready = '0;
      if (state_q == StLocked) begin
         ready[grant_q] = out_free;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         last_q    <= CH_W'(N_CH - 1);
         data_q    <= '0;
         valid_q   <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         channel_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (found) begin
                  grant_q <= next_win;
                  last_q  <= next_win;
                  state_q <= StLocked;
               end
            end
            StLocked: begin
               if (accept && bus.src_eop_i[grant_q]) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (accept) begin
            data_q    <= gnt_data;
            sop_q     <= bus.src_sop_i[grant_q];
            eop_q     <= bus.src_eop_i[grant_q];
            channel_q <= grant_q;
            valid_q   <= 1'b1;
         end else if (valid_q && bus.snk_ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.src_ready_o   = ready;
   assign bus.snk_data_o    = data_q;
   assign bus.snk_valid_o   = valid_q;
   assign bus.snk_sop_o     = sop_q;
   assign bus.snk_eop_o     = eop_q;
   assign bus.snk_channel_o = channel_q;
   assign bus.busy_o        = (state_q == StLocked);
endmodule

// File: tb/tb_avalon_st_arbiter.sv
// Bench for avalon_st_arbiter: directed scenarios with cycle-exact expectations
// plus a randomized run scored against per-source packet queues and a
// round-robin winner model evaluated from the valid vector seen while idle.
module tb_avalon_st_arbiter;
   localparam int unsigned N_CH  = 4;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned CH_W  = 2;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             sop;
      logic             eop;
   } beat_t;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [CH_W-1:0]  ch;
      logic             sop;
      logic             eop;
   } out_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   avalon_st_arbiter_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

   avalon_st_arbiter #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   beat_t           src_q[N_CH][$];
   beat_t           exp_q[N_CH][$];
   logic [N_CH-1:0] hold = '0;
   logic [N_CH-1:0] hs   = '0;
   out_t            out_log[$];
   int              exp_win_q[$];
   int              onehot_viol = 0;

   // Per-cycle stimulus patterns and samples for directed tests.
   logic            rdy_pat [64];
   logic [N_CH-1:0] hold_pat[64];
   logic            s_valid [64];
   logic [WIDTH-1:0] s_data [64];
   logic [CH_W-1:0] s_ch    [64];
   logic            s_sop   [64];
   logic            s_eop   [64];
   logic            s_busy  [64];
   logic [N_CH-1:0] s_ready [64];

   // Source driver: pop on the handshake seen before the edge, then present the head.
   initial begin
      logic [N_CH*WIDTH-1:0] d;
      logic [N_CH-1:0]       v, s, e;
      bus.src_data_i  = '0;
      bus.src_valid_i = '0;
      bus.src_sop_i   = '0;
      bus.src_eop_i   = '0;
      bus.snk_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         d = '0; v = '0; s = '0; e = '0;
         for (int k = 0; k < N_CH; k++) begin
            if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (src_q[k].size() > 0) begin
               v[k] = !hold[k];
               d[k*WIDTH +: WIDTH] = src_q[k][0].data;
               s[k] = src_q[k][0].sop;
               e[k] = src_q[k][0].eop;
            end
         end
         bus.src_data_i  = d;
         bus.src_valid_i = v;
         bus.src_sop_i   = s;
         bus.src_eop_i   = e;
      end
   end

   // Monitor: handshakes, sink transfers, ready exclusivity, round-robin winner model.
   initial begin
      int              m_last;
      logic            prev_busy;
      logic [N_CH-1:0] idle_valid;
      int              w;
      out_t            o;
      m_last = N_CH - 1;
      prev_busy = 1'b0;
      idle_valid = '0;
      forever begin
         @(negedge clk);
         hs = bus.src_valid_i & bus.src_ready_o & {N_CH{rst_n}};
         if (!rst_n) begin
            m_last = N_CH - 1;
            prev_busy = 1'b0;
         end else begin
            if (bus.snk_valid_o && bus.snk_ready_i) begin
               o.data = bus.snk_data_o;
               o.ch   = bus.snk_channel_o;
               o.sop  = bus.snk_sop_o;
               o.eop  = bus.snk_eop_o;
               out_log.push_back(o);
            end
            if (!$onehot0(bus.src_ready_o)) onehot_viol++;
            if (!bus.busy_o) begin
               idle_valid = bus.src_valid_i;
            end else if (!prev_busy) begin
               w = -1;
               for (int dd = 1; dd <= N_CH; dd++) begin
                  if (w < 0 && idle_valid[(m_last + dd) % N_CH]) w = (m_last + dd) % N_CH;
               end
               exp_win_q.push_back(w);
               if (w >= 0) m_last = w;
            end
            prev_busy = bus.busy_o;
         end
      end
   end

   task automatic push_pkt(input int k, input int n, input logic [WIDTH-1:0] base);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = base + WIDTH'(i);
         b.sop  = (i == 0);
         b.eop  = (i == n - 1);
         src_q[k].push_back(b);
      end
   endtask

   task automatic clear_pats();
      for (int i = 0; i < 64; i++) begin
         rdy_pat[i]  = 1'b1;
         hold_pat[i] = '0;
      end
   endtask

   // Ends at 1 time unit after a rising edge: cycle 0 of the next scenario.
   task automatic do_reset();
      rst_n = 1'b0;
      hs = '0;
      for (int k = 0; k < N_CH; k++) src_q[k].delete();
      hold = '0;
      bus.snk_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      out_log.delete();
      exp_win_q.delete();
      rst_n = 1'b1;
      clear_pats();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         bus.snk_ready_i = rdy_pat[i];
         hold = hold_pat[i];
         @(negedge clk);
         s_valid[i] = bus.snk_valid_o;
         s_data[i]  = bus.snk_data_o;
         s_ch[i]    = bus.snk_channel_o;
         s_sop[i]   = bus.snk_sop_o;
         s_eop[i]   = bus.snk_eop_o;
         s_busy[i]  = bus.busy_o;
         s_ready[i] = bus.src_ready_o;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (bus.snk_valid_o !== 1'b0) begin errors++;
         $display("FAIL reset snk_valid: got %b want 0", bus.snk_valid_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++;
         $display("FAIL reset busy: got %b want 0", bus.busy_o); end
      checks++; if (bus.src_ready_o !== '0) begin errors++;
         $display("FAIL reset src_ready: got %b want 0", bus.src_ready_o); end
      checks++; if (bus.snk_data_o !== '0) begin errors++;
         $display("FAIL reset snk_data: got %h want 0", bus.snk_data_o); end
      checks++; if ({bus.snk_sop_o, bus.snk_eop_o, bus.snk_channel_o} !== '0) begin errors++;
         $display("FAIL reset sop/eop/channel: got %b%b/%0d want 00/0",
                  bus.snk_sop_o, bus.snk_eop_o, bus.snk_channel_o); end
   endtask

   task automatic test_single();
      logic ev, eb;
      do_reset();
      push_pkt(2, 3, 'hA0);
      run(7);
      for (int i = 0; i < 7; i++) begin
         ev = (i >= 2 && i <= 4);
         eb = (i >= 1 && i <= 3);
         checks++; if (s_valid[i] !== ev) begin errors++;
            $display("FAIL single valid c%0d: got %b want %b", i, s_valid[i], ev); end
         checks++; if (s_busy[i] !== eb) begin errors++;
            $display("FAIL single busy c%0d: got %b want %b", i, s_busy[i], eb); end
         checks++; if (s_ready[i] !== (eb ? 4'b0100 : 4'b0000)) begin errors++;
            $display("FAIL single ready c%0d: got %b want %b", i, s_ready[i], eb ? 4'b0100 : 4'b0); end
         if (ev) begin
            checks++;
            if ({s_data[i], s_ch[i], s_sop[i], s_eop[i]} !==
                {WIDTH'('hA0 + i - 2), 2'd2, (i == 2), (i == 4)}) begin
               errors++;
               $display("FAIL single beat c%0d: got %h ch%0d sop%b eop%b want %h ch2 sop%b eop%b",
                        i, s_data[i], s_ch[i], s_sop[i], s_eop[i], 'hA0 + i - 2, i == 2, i == 4);
            end
         end
      end
   endtask

   task automatic test_contention();
      logic ev;
      logic [WIDTH-1:0] ed;
      int ec;
      do_reset();
      for (int k = 0; k < N_CH; k++) push_pkt(k, 2, WIDTH'('h100 * (k + 1)));
      run(15);
      for (int i = 0; i < 15; i++) begin
         ev = 1'b0; ed = '0; ec = 0;
         for (int p = 0; p < N_CH; p++) begin
            for (int b = 0; b < 2; b++) begin
               if (i == 2 + 3 * p + b) begin
                  ev = 1'b1; ed = WIDTH'('h100 * (p + 1) + b); ec = p;
               end
            end
         end
         checks++; if (s_valid[i] !== ev) begin errors++;
            $display("FAIL contention valid c%0d: got %b want %b", i, s_valid[i], ev); end
         if (ev) begin
            checks++; if (s_data[i] !== ed || s_ch[i] !== CH_W'(ec)) begin errors++;
               $display("FAIL contention beat c%0d: got %h ch%0d want %h ch%0d",
                        i, s_data[i], s_ch[i], ed, ec); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      push_pkt(0, 4, 'hD0);
      for (int i = 3; i <= 5; i++) rdy_pat[i] = 1'b0;
      run(11);
      for (int i = 3; i <= 6; i++) begin
         checks++; if (s_valid[i] !== 1'b1 || s_data[i] !== 'hD1) begin errors++;
            $display("FAIL backpressure hold c%0d: got v%b %h want v1 d1", i, s_valid[i], s_data[i]); end
      end
      for (int i = 3; i <= 5; i++) begin
         checks++; if (s_ready[i][0] !== 1'b0) begin errors++;
            $display("FAIL backpressure ready c%0d: got %b want 0", i, s_ready[i][0]); end
      end
      checks++; if (out_log.size() != 4) begin errors++;
         $display("FAIL backpressure count: got %0d want 4", out_log.size()); end
      for (int i = 0; i < out_log.size() && i < 4; i++) begin
         checks++; if (out_log[i].data !== WIDTH'('hD0 + i)) begin errors++;
            $display("FAIL backpressure order %0d: got %h want %h", i, out_log[i].data, 'hD0 + i); end
      end
   endtask

   task automatic test_valid_gap();
      logic [WIDTH-1:0] ed[6];
      logic [CH_W-1:0]  ec[6];
      ed = '{'hB0, 'hB1, 'hB2, 'hB3, 'hC0, 'hC1};
      ec = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
      do_reset();
      push_pkt(1, 4, 'hB0);
      push_pkt(3, 2, 'hC0);
      hold_pat[3] = 4'b0010;
      hold_pat[4] = 4'b0010;
      run(14);
      for (int i = 0; i < 8; i++) begin
         checks++; if (s_ready[i][3] !== 1'b0) begin errors++;
            $display("FAIL gap early ready3 c%0d: got %b want 0", i, s_ready[i][3]); end
      end
      for (int i = 1; i <= 6; i++) begin
         checks++; if (s_busy[i] !== 1'b1) begin errors++;
            $display("FAIL gap busy c%0d: got %b want 1", i, s_busy[i]); end
      end
      checks++; if (s_valid[4] !== 1'b0 || s_valid[5] !== 1'b0) begin errors++;
         $display("FAIL gap bubble: got %b%b want 00", s_valid[4], s_valid[5]); end
      checks++; if (s_ready[8] !== 4'b1000) begin errors++;
         $display("FAIL gap grant3 ready: got %b want 1000", s_ready[8]); end
      checks++; if (out_log.size() != 6) begin errors++;
         $display("FAIL gap count: got %0d want 6", out_log.size()); end
      for (int i = 0; i < out_log.size() && i < 6; i++) begin
         checks++; if (out_log[i].data !== ed[i] || out_log[i].ch !== ec[i]) begin errors++;
            $display("FAIL gap order %0d: got %h ch%0d want %h ch%0d",
                     i, out_log[i].data, out_log[i].ch, ed[i], ec[i]); end
      end
   endtask

   task automatic test_single_beat();
      logic ev;
      int m;
      do_reset();
      for (int j = 0; j < 4; j++) begin
         push_pkt(0, 1, WIDTH'('hE0 + j));
         push_pkt(1, 1, WIDTH'('hF0 + j));
      end
      run(19);
      for (int i = 1; i < 19; i++) begin
         ev = (i >= 2) && (i <= 16) && (i % 2 == 0);
         checks++; if (s_valid[i] !== ev) begin errors++;
            $display("FAIL singlebeat valid c%0d: got %b want %b", i, s_valid[i], ev); end
         if (ev) begin
            m = (i - 2) / 2;
            checks++;
            if (s_ch[i] !== CH_W'(m % 2) ||
                s_data[i] !== WIDTH'(((m % 2) ? 'hF0 : 'hE0) + m / 2) ||
                s_sop[i] !== 1'b1 || s_eop[i] !== 1'b1) begin
               errors++;
               $display("FAIL singlebeat beat c%0d: got %h ch%0d sop%b eop%b want ch%0d sop1 eop1",
                        i, s_data[i], s_ch[i], s_sop[i], s_eop[i], m % 2);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push_pkt(1, 5, 'h50);
      run(4);
      checks++; if (s_data[3] !== 'h51 || s_valid[3] !== 1'b1) begin errors++;
         $display("FAIL rstmid beat2: got v%b %h want v1 51", s_valid[3], s_data[3]); end
      rst_n = 1'b0;
      hs = '0;
      for (int k = 0; k < N_CH; k++) src_q[k].delete();
      #1;
      checks++;
      if (bus.snk_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.src_ready_o !== '0) begin
         errors++;
         $display("FAIL rstmid immediate: got v%b busy%b rdy%b want 0 0 0000",
                  bus.snk_valid_o, bus.busy_o, bus.src_ready_o);
      end
      @(posedge clk);
      #1;
      out_log.delete();
      exp_win_q.delete();
      push_pkt(0, 1, 'h60);
      push_pkt(1, 1, 'h61);
      rst_n = 1'b1;
      clear_pats();
      run(6);
      checks++; if (s_ready[1] !== 4'b0001) begin errors++;
         $display("FAIL rstmid first grant: got %b want 0001", s_ready[1]); end
      checks++;
      if (out_log.size() != 2 || out_log[0].ch !== 2'd0 || out_log[0].data !== 'h60) begin
         errors++;
         $display("FAIL rstmid first beat: got n=%0d ch%0d %h want n=2 ch0 60",
                  out_log.size(), out_log.size() > 0 ? out_log[0].ch : 2'd0,
                  out_log.size() > 0 ? out_log[0].data : '0);
      end
   endtask

   task automatic test_random();
      beat_t b;
      int    npk, len, ew, cur, cyc_n;
      logic  done, open;
      do_reset();
      for (int k = 0; k < N_CH; k++) begin
         exp_q[k].delete();
         npk = 3 + int'($urandom_range(2, 0));
         for (int p = 0; p < npk; p++) begin
            len = 1 + int'($urandom_range(4, 0));
            for (int i = 0; i < len; i++) begin
               b.data = $urandom;
               b.sop  = (i == 0);
               b.eop  = (i == len - 1);
               src_q[k].push_back(b);
               exp_q[k].push_back(b);
            end
         end
      end
      done = 1'b0;
      cyc_n = 0;
      while (!done && cyc_n < 3000) begin
         bus.snk_ready_i = ($urandom_range(3, 0) != 0);
         for (int k = 0; k < N_CH; k++) hold[k] = ($urandom_range(4, 0) == 0);
         @(negedge clk);
         done = !bus.snk_valid_o && !bus.busy_o;
         for (int k = 0; k < N_CH; k++) if (src_q[k].size() != 0) done = 1'b0;
         @(posedge clk);
         #1;
         cyc_n++;
      end
      hold = '0;
      bus.snk_ready_i = 1'b1;
      checks++; if (!done) begin errors++;
         $display("FAIL random drain: got not done after %0d cycles want done", cyc_n); end
      open = 1'b0;
      cur = 0;
      foreach (out_log[i]) begin
         if (out_log[i].sop) begin
            ew = (exp_win_q.size() > 0) ? exp_win_q.pop_front() : -1;
            checks++; if (int'(out_log[i].ch) != ew) begin errors++;
               $display("FAIL random winner beat%0d: got ch%0d want ch%0d", i, out_log[i].ch, ew); end
         end
         checks++; if (open && out_log[i].ch != CH_W'(cur)) begin errors++;
            $display("FAIL random interleave beat%0d: got ch%0d want ch%0d", i, out_log[i].ch, cur); end
         if (exp_q[out_log[i].ch].size() == 0) begin
            checks++; errors++;
            $display("FAIL random extra beat%0d: got ch%0d %h want none", i, out_log[i].ch, out_log[i].data);
         end else begin
            b = exp_q[out_log[i].ch].pop_front();
            checks++;
            if ({out_log[i].data, out_log[i].sop, out_log[i].eop} !== {b.data, b.sop, b.eop}) begin
               errors++;
               $display("FAIL random beat%0d ch%0d: got %h %b%b want %h %b%b", i, out_log[i].ch,
                        out_log[i].data, out_log[i].sop, out_log[i].eop, b.data, b.sop, b.eop);
            end
         end
         cur  = int'(out_log[i].ch);
         open = !out_log[i].eop;
      end
      for (int k = 0; k < N_CH; k++) begin
         checks++; if (exp_q[k].size() != 0) begin errors++;
            $display("FAIL random lost ch%0d: got %0d beats missing want 0", k, exp_q[k].size()); end
      end
      checks++; if (onehot_viol != 0) begin errors++;
         $display("FAIL ready onehot: got %0d violations want 0", onehot_viol); end
   endtask

   initial begin
      clear_pats();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_valid_gap();
      test_single_beat();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
